// File: rtl/mac_sw_pkg.sv
// Shared definitions for the MAC switch ingress path: header geometry, port count
// and the arbiter FSM encoding (also decoded by the switch core).
package mac_sw_pkg;

  localparam int NPORTS        = 4;
  localparam int PORT_W        = 2;
  localparam int HDR_W         = 113;
  localparam int SHDR_W        = 115;
  localparam int HDR_VALID_BIT = 112;
  localparam int HDR_DST_LSB   = 64;
  localparam int HDR_SRC_LSB   = 16;
  localparam int HDR_TYPE_LSB  = 0;
  localparam int HDR_FIELDS_W  = 112;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_HEADER  = 3'd3
  } arb_state_e;

  // A truncated frame keeps its address fields but is always marked invalid.
  function automatic logic [SHDR_W-1:0] tag_header(input logic [HDR_W-1:0]  hdr,
                                                   input logic [PORT_W-1:0] port,
                                                   input logic              trunc);
    return {hdr[HDR_VALID_BIT] & ~trunc, port, hdr[HDR_FIELDS_W-1:0]};
  endfunction

endpackage

// File: rtl/mac_ingress_arbiter_rr_arb4.sv
// Four-way round-robin picker: first requesting port after the pointer, cyclic.
// Purely combinational; the caller owns the pointer register.
module rr_arb4
  import mac_sw_pkg::*;
(
  input  logic [NPORTS-1:0] req_i,
  input  logic [PORT_W-1:0] ptr_i,
  output logic [NPORTS-1:0] gnt_o,
  output logic [PORT_W-1:0] idx_o
);

  logic              found;
  logic [PORT_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    // The offset wraps modulo 4, so the pointer port itself is tried last.
    for (int i = 1; i <= NPORTS; i++) begin
      cand = ptr_i + PORT_W'(i);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/mac_ingress_arbiter.sv
// Moves whole frames from four RX FIFO pairs into the shared header/payload FIFOs,
// payload first and header last, one frame at a time in round-robin order.
module mac_ingress_arbiter
  import mac_sw_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1500,
  parameter int CNT_W       = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPORTS*HDR_W-1:0] p_h_dout,
  input  logic [NPORTS-1:0]       p_h_empty,
  output logic [NPORTS-1:0]       p_h_rden,
  input  logic [NPORTS*8-1:0]     p_b_dout,
  input  logic [NPORTS-1:0]       p_b_del,
  input  logic [NPORTS-1:0]       p_b_empty,
  output logic [NPORTS-1:0]       p_b_rden,
  output logic [SHDR_W-1:0]       sh_h_din,
  output logic                    sh_h_wren,
  input  logic                    sh_h_afull,
  output logic [7:0]              sh_b_din,
  output logic                    sh_b_del,
  output logic                    sh_b_wren,
  input  logic                    sh_b_afull,
  output logic                    busy
);

  arb_state_e        state_q, state_d;
  logic [PORT_W-1:0] rr_q, rr_d;
  logic [PORT_W-1:0] g_q, g_d;
  logic [NPORTS-1:0] gsel_q, gsel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              trunc_q, trunc_d;
  logic              bw_q, bw_d;
  logic              bdel_q, bdel_d;
  logic [7:0]        bdin_q, bdin_d;
  logic              hw_q, hw_d;
  logic [SHDR_W-1:0] hdin_q, hdin_d;

  logic [NPORTS-1:0] arb_gnt;
  logic [PORT_W-1:0] arb_idx;
  logic              cnt_at_max;

  logic [HDR_W-1:0]  hdr_a  [NPORTS];
  logic [7:0]        byte_a [NPORTS];

  for (genvar n = 0; n < NPORTS; n++) begin : g_split
    assign hdr_a[n]  = p_h_dout[n*HDR_W +: HDR_W];
    assign byte_a[n] = p_b_dout[n*8 +: 8];
  end

  rr_arb4 u_rr (
    .req_i (~p_h_empty),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // True when the byte about to move is the MAX_PAYLOAD-th of the frame.
  assign cnt_at_max = (cnt_q == CNT_W'(MAX_PAYLOAD - 1));

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    g_d      = g_q;
    gsel_d   = gsel_q;
    cnt_d    = cnt_q;
    trunc_d  = trunc_q;
    bw_d     = 1'b0;
    bdel_d   = 1'b0;
    bdin_d   = bdin_q;
    hw_d     = 1'b0;
    hdin_d   = hdin_q;
    p_b_rden = '0;
    p_h_rden = '0;
    case (state_q)
      ST_IDLE: begin
        if (|(~p_h_empty)) begin
          g_d     = arb_idx;
          gsel_d  = arb_gnt;
          rr_d    = arb_idx;
          cnt_d   = '0;
          trunc_d = 1'b0;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!p_b_empty[g_q] && !sh_b_afull) begin
          p_b_rden = gsel_q;
          bw_d     = 1'b1;
          bdin_d   = byte_a[g_q];
          cnt_d    = cnt_q + CNT_W'(1);
          if (p_b_del[g_q]) begin
            bdel_d  = 1'b1;
            state_d = ST_HEADER;
          end else if (cnt_at_max) begin
            bdel_d  = 1'b1;
            trunc_d = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!p_b_empty[g_q]) begin
          p_b_rden = gsel_q;
          if (p_b_del[g_q]) state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (!sh_h_afull) begin
          p_h_rden = gsel_q;
          hw_d     = 1'b1;
          hdin_d   = tag_header(hdr_a[g_q], g_q, trunc_q);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= PORT_W'(NPORTS - 1);
      g_q     <= '0;
      gsel_q  <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
      bw_q    <= 1'b0;
      bdel_q  <= 1'b0;
      bdin_q  <= '0;
      hw_q    <= 1'b0;
      hdin_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      gsel_q  <= gsel_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
      bw_q    <= bw_d;
      bdel_q  <= bdel_d;
      bdin_q  <= bdin_d;
      hw_q    <= hw_d;
      hdin_q  <= hdin_d;
    end
  end

  assign sh_b_wren = bw_q;
  assign sh_b_del  = bdel_q;
  assign sh_b_din  = bdin_q;
  assign sh_h_wren = hw_q;
  assign sh_h_din  = hdin_q;
  assign busy      = (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN) ||
                     (state_q == ST_HEADER);

endmodule

// File: tb/tb_mac_ingress_arbiter.sv
// Bench for mac_ingress_arbiter: queue-based RX FIFO models, a per-port frame
// scoreboard, an arbitration-order table and directed multi-cycle corner cases.
module tb_mac_ingress_arbiter;

  localparam int MAXP = 1500;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [451:0]  p_h_dout;
  logic [3:0]    p_h_empty, p_h_rden;
  logic [31:0]   p_b_dout;
  logic [3:0]    p_b_del, p_b_empty, p_b_rden;
  logic [114:0]  sh_h_din;
  logic          sh_h_wren, sh_h_afull;
  logic [7:0]    sh_b_din;
  logic          sh_b_del, sh_b_wren, sh_b_afull, busy;

  always #5 clk = ~clk;

  mac_ingress_arbiter #(.MAX_PAYLOAD(MAXP), .CNT_W(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_h_dout(p_h_dout), .p_h_empty(p_h_empty), .p_h_rden(p_h_rden),
    .p_b_dout(p_b_dout), .p_b_del(p_b_del), .p_b_empty(p_b_empty), .p_b_rden(p_b_rden),
    .sh_h_din(sh_h_din), .sh_h_wren(sh_h_wren), .sh_h_afull(sh_h_afull),
    .sh_b_din(sh_b_din), .sh_b_del(sh_b_del), .sh_b_wren(sh_b_wren), .sh_b_afull(sh_b_afull),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // RX FIFO contents, bytes held back for later arrival, and expected shared output.
  logic [8:0]   pb_q   [4][$];
  logic [8:0]   late_q [4][$];
  logic [112:0] ph_q   [4][$];
  logic [8:0]   exp_b  [4][$];
  logic [114:0] exp_h  [4][$];
  logic [8:0]   cur [$];
  int           served [$];
  int           hpop_cnt [4];
  int           bwr_cnt;
  logic [114:0] last_hdr;
  bit           stall_chk;
  int           stall_cyc;

  typedef struct packed {
    logic [3:0] mask;
    logic [2:0] n;
    logic [1:0] o0, o1, o2, o3;
  } vec_t;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic drive_ports();
    for (int p = 0; p < 4; p++) begin
      p_h_empty[p] = (ph_q[p].size() == 0);
      if (ph_q[p].size() == 0) p_h_dout[p*113 +: 113] = '0;
      else                     p_h_dout[p*113 +: 113] = ph_q[p][0];
      p_b_empty[p] = (pb_q[p].size() == 0);
      if (pb_q[p].size() == 0) begin
        p_b_dout[p*8 +: 8] = '0;
        p_b_del[p]         = 1'b0;
      end else begin
        p_b_dout[p*8 +: 8] = pb_q[p][0][7:0];
        p_b_del[p]         = pb_q[p][0][8];
      end
    end
  endtask

  // Expected output derived from the frame itself: first MAXP bytes, last one
  // delimited, header valid only if the frame fit.
  task automatic add_frame(input int p, input int len, input logic [7:0] base,
                           input bit rnd, input bit hv, input int split);
    logic [112:0] h;
    logic [7:0]   b;
    logic         d;
    h = {hv, 112'({$urandom(), $urandom(), $urandom(), $urandom()})};
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom()) : base + 8'(i);
      d = (i == len - 1);
      if (i < split) pb_q[p].push_back({d, b});
      else           late_q[p].push_back({d, b});
      if (i < MAXP) exp_b[p].push_back({d | (i == MAXP - 1), b});
    end
    ph_q[p].push_back(h);
    exp_h[p].push_back({hv & (len <= MAXP), 2'(p), h[111:0]});
    drive_ports();
  endtask

  task automatic push_late(input int p);
    while (late_q[p].size() > 0) pb_q[p].push_back(late_q[p].pop_front());
    drive_ports();
  endtask

  task automatic clear_all();
    for (int p = 0; p < 4; p++) begin
      pb_q[p].delete(); late_q[p].delete(); ph_q[p].delete();
      exp_b[p].delete(); exp_h[p].delete(); hpop_cnt[p] = 0;
    end
    cur.delete();
    served.delete();
    drive_ports();
  endtask

  task automatic frame_done(input logic [114:0] h);
    int         p;
    bit         ok;
    int         bad_i;
    logic [8:0] e, eb;
    p     = int'(h[113:112]);
    ok    = (cur.size() > 0);
    bad_i = -1;
    eb    = '0;
    for (int i = 0; i < cur.size(); i++) begin
      if (exp_b[p].size() == 0) e = 9'h1ff;
      else                      e = exp_b[p].pop_front();
      if (e !== cur[i] && ok) begin
        ok = 0; bad_i = i; eb = e;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      if (bad_i < 0)
        $display("FAIL frame_bytes port %0d: got %0d bytes want >=1", p, cur.size());
      else
        $display("FAIL frame_bytes port %0d byte %0d: got %h want %h", p, bad_i, cur[bad_i], eb);
    end
    if (exp_h[p].size() == 0) check("frame_hdr_unexpected", h, 0);
    else                      check("frame_hdr", h, exp_h[p].pop_front());
    last_hdr = h;
    cur.delete();
  endtask

  task automatic tick();
    logic [3:0] bp, hp;
    bit         legal;
    @(negedge clk);
    bp = p_b_rden;
    hp = p_h_rden;
    if (rst_n && (bp != 0 || hp != 0)) begin
      legal = $onehot0(bp) && $onehot0(hp) && !(bp != 0 && hp != 0);
      for (int p = 0; p < 4; p++) begin
        if (bp[p] && pb_q[p].size() == 0) legal = 0;
        if (hp[p] && ph_q[p].size() == 0) legal = 0;
      end
      check("rden_legal", {bp, hp}, legal ? {bp, hp} : 8'hxx);
    end
    if (stall_chk) begin
      check("stall_no_pop", bp, 0);
      if (stall_cyc > 0) check("stall_no_wr", sh_b_wren, 0);
      stall_cyc++;
    end
    if (rst_n && sh_b_wren) begin
      cur.push_back({sh_b_del, sh_b_din});
      bwr_cnt++;
    end
    if (rst_n && sh_h_wren) frame_done(sh_h_din);
    for (int p = 0; p < 4; p++)
      if (rst_n && hp[p]) begin
        served.push_back(p);
        hpop_cnt[p]++;
      end
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (bp[p] && pb_q[p].size() > 0) void'(pb_q[p].pop_front());
      if (hp[p] && ph_q[p].size() > 0) void'(ph_q[p].pop_front());
    end
    drive_ports();
  endtask

  function automatic bit ports_empty();
    for (int p = 0; p < 4; p++)
      if (pb_q[p].size() + late_q[p].size() + ph_q[p].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_idle(input int budget);
    int quiet = 0;
    for (int c = 0; c < budget && quiet < 3; c++) begin
      tick();
      if (ports_empty() && !busy && !sh_h_wren && !sh_b_wren) quiet++;
      else quiet = 0;
    end
    check("idle_timeout", quiet, 3);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int c = 0; c < budget && bwr_cnt < n; c++) tick();
    check("bytes_timeout", bwr_cnt >= n, 1);
  endtask

  task automatic check_order(input string name, input int n, input int e0, input int e1,
                             input int e2, input int e3, input int e4);
    logic [2:0]  exp_v [5];
    logic [18:0] got_p, exp_p;
    exp_v[0] = 3'(e0); exp_v[1] = 3'(e1); exp_v[2] = 3'(e2);
    exp_v[3] = 3'(e3); exp_v[4] = 3'(e4);
    got_p = '0; exp_p = '0;
    got_p[18:15] = 4'(served.size());
    exp_p[18:15] = 4'(n);
    for (int i = 0; i < 5; i++) begin
      if (i < served.size()) got_p[3*i +: 3] = 3'(served[i]);
      if (i < n)             exp_p[3*i +: 3] = exp_v[i];
    end
    check(name, got_p, exp_p);
  endtask

  initial begin
    vec_t vecs [6];
    int   len, p, sent;
    vecs[0] = '{4'b1111, 3'd4, 2'd0, 2'd1, 2'd2, 2'd3};
    vecs[1] = '{4'b0110, 3'd2, 2'd1, 2'd2, 2'd0, 2'd0};
    vecs[2] = '{4'b1011, 3'd3, 2'd3, 2'd0, 2'd1, 2'd0};
    vecs[3] = '{4'b0001, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[4] = '{4'b1001, 3'd2, 2'd3, 2'd0, 2'd0, 2'd0};
    vecs[5] = '{4'b1100, 3'd2, 2'd2, 2'd3, 2'd0, 2'd0};

    rst_n = 1'b0; sh_h_afull = 1'b0; sh_b_afull = 1'b0;
    stall_chk = 0; stall_cyc = 0; bwr_cnt = 0; last_hdr = '0;
    p_h_dout = '0; p_b_dout = '0; p_h_empty = '1; p_b_empty = '1; p_b_del = '0;
    clear_all();
    repeat (3) tick();
    check("rst_sh_h_wren", sh_h_wren, 0);
    check("rst_sh_b_wren", sh_b_wren, 0);
    check("rst_sh_b_del",  sh_b_del,  0);
    check("rst_busy",      busy,      0);
    check("rst_sh_h_din",  sh_h_din,  0);
    check("rst_sh_b_din",  sh_b_din,  0);
    check("rst_p_h_rden",  p_h_rden,  0);
    check("rst_p_b_rden",  p_b_rden,  0);
    rst_n = 1'b1;

    // Single port, incrementing payload.
    bwr_cnt = 0;
    add_frame(2, 60, 8'h00, 0, 1, 60);
    wait_idle(500);
    check("t1_bytes", bwr_cnt, 60);
    check("t1_hpop2", hpop_cnt[2], 1);
    check("t1_hpop_other", hpop_cnt[0] + hpop_cnt[1] + hpop_cnt[3], 0);
    check("t1_hdr_top", last_hdr[114:112], 3'b110);

    rst_n = 1'b0; tick(); rst_n = 1'b1; clear_all();

    // Arbitration order table; pointer carries over between rows.
    for (int e = 0; e < 6; e++) begin
      served.delete();
      for (int q = 0; q < 4; q++)
        if (vecs[e].mask[q]) begin
          len = $urandom_range(1, 12);
          add_frame(q, len, 8'h00, 1, 1'($urandom_range(0, 1)), len);
        end
      wait_idle(800);
      check_order($sformatf("order_row%0d", e), int'(vecs[e].n), int'(vecs[e].o0),
                  int'(vecs[e].o1), int'(vecs[e].o2), int'(vecs[e].o3), 0);
    end

    // Refill port 1 while port 3 is being served.
    served.delete();
    for (int q = 0; q < 4; q++) add_frame(q, 30, 8'h00, 1, 1, 30);
    for (int c = 0; c < 1000 && served.size() < 3; c++) tick();
    check("t2_wait", served.size() >= 3, 1);
    add_frame(1, 10, 8'h00, 1, 1, 10);
    wait_idle(1000);
    check_order("t2_refill_order", 5, 0, 1, 2, 3, 1);

    // Shared payload FIFO back-pressure mid-frame.
    bwr_cnt = 0;
    add_frame(0, 40, 8'h80, 0, 1, 40);
    wait_bytes(15, 200);
    sh_b_afull = 1'b1; stall_chk = 1; stall_cyc = 0;
    repeat (10) tick();
    stall_chk = 0; sh_b_afull = 1'b0;
    wait_idle(300);
    check("t3_bytes", bwr_cnt, 40);

    // Oversized frame is truncated and drained.
    bwr_cnt = 0;
    add_frame(3, 1510, 8'h00, 1, 1, 1510);
    wait_idle(3000);
    check("t4_bytes", bwr_cnt, MAXP);
    check("t4_hdr_valid", last_hdr[114], 0);
    check("t4_drained", pb_q[3].size(), 0);

    // Granted payload FIFO runs dry while another port becomes ready.
    served.delete();
    add_frame(1, 20, 8'h40, 0, 1, 10);
    for (int c = 0; c < 100 && pb_q[1].size() > 0; c++) tick();
    add_frame(0, 1, 8'h5A, 0, 1, 1);
    stall_chk = 1; stall_cyc = 0;
    repeat (5) begin
      tick();
      check("t5_busy", busy, 1);
    end
    stall_chk = 0;
    push_late(1);
    wait_idle(300);
    check_order("t5_order", 2, 1, 0, 0, 0, 0);

    // Reset in the middle of a payload transfer.
    bwr_cnt = 0;
    add_frame(1, 50, 8'hA0, 0, 1, 50);
    wait_bytes(5, 100);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_all();
    check("t6_sh_b_wren", sh_b_wren, 0);
    check("t6_sh_b_din",  sh_b_din,  0);
    check("t6_sh_b_del",  sh_b_del,  0);
    check("t6_sh_h_wren", sh_h_wren, 0);
    check("t6_busy",      busy,      0);
    check("t6_p_b_rden",  p_b_rden,  0);
    add_frame(2, 5, 8'h00, 1, 1, 5);
    add_frame(0, 5, 8'h00, 1, 1, 5);
    wait_idle(200);
    check_order("t6_order", 2, 0, 2, 0, 0, 0);

    // Randomized traffic with random back-pressure on both shared FIFOs.
    sent = 0;
    for (int c = 0; c < 6000 && sent < 40; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(0, 3);
        if (ph_q[p].size() < 3) begin
          len = $urandom_range(1, 40);
          add_frame(p, len, 8'h00, 1, 1'($urandom_range(0, 1)), len);
          sent++;
        end
      end
      sh_b_afull = ($urandom_range(0, 3) == 0);
      sh_h_afull = ($urandom_range(0, 4) == 0);
      tick();
    end
    sh_b_afull = 1'b0; sh_h_afull = 1'b0;
    wait_idle(3000);
    for (int q = 0; q < 4; q++)
      check($sformatf("end_exp_empty_p%0d", q), exp_b[q].size() + exp_h[q].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
